// File: rtl/cpu_seq_pkg.sv
// Shared types and field layout for the CPU issue sequencer.
package cpu_seq_pkg;

   localparam int INSTR_W = 10;
   localparam int R_W     = 5;
   localparam int OP_HI   = 9;
   localparam int OP_LO   = 8;

   localparam int FLAG_CF = 0;
   localparam int FLAG_SF = 1;
   localparam int FLAG_ZF = 2;
   localparam int FLAG_GF = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2,
      ST_HALT  = 2'd3
   } seq_state_e;

   function automatic logic [1:0] opcode(input logic [INSTR_W-1:0] instr);
      return instr[OP_HI:OP_LO];
   endfunction

endpackage

// File: rtl/seq_fifo.sv
// Small synchronous FIFO with wrap-bit pointers for the instruction queue.
module seq_fifo
   import cpu_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = INSTR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             do_push, do_pop;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign rdata = mem_q[rd_q[AW-1:0]];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/cpu_issue_sequencer.sv
// Feeds queued instructions to the combinational CPU one at a time and
// registers its result and flags into a valid/ready result stage.
module cpu_issue_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   output logic [INSTR_W-1:0] cpu_pi,
   input  logic [R_W-1:0]     cpu_r,
   input  logic               cpu_cf,
   input  logic               cpu_sf,
   input  logic               cpu_zf,
   input  logic               cpu_gf,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [R_W-1:0]     res_r,
   output logic [3:0]         res_flags,
   input  logic               halt_on_zf,
   input  logic               resume,
   output logic               halted,
   output logic               busy,
   output logic [CNT_W-1:0]   issue_count
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   seq_state_e         state_q, state_d;
   logic [INSTR_W-1:0] pi_q, pi_d;
   logic [SW-1:0]      settle_q, settle_d;
   logic               valid_q, valid_d;
   logic [R_W-1:0]     r_q, r_d;
   logic [3:0]         flags_q, flags_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               fifo_full, fifo_empty, pop;
   logic [INSTR_W-1:0] head;

   assign in_ready = !fifo_full;

   seq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid && !fifo_full),
      .wdata (in_instr),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      pi_d     = pi_q;
      settle_d = settle_q;
      valid_d  = valid_q;
      r_d      = r_q;
      flags_d  = flags_q;
      count_d  = count_q;
      pop      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               pi_d     = head;
               settle_d = SW'(SETTLE - 1);
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (settle_q == '0) begin
               r_d              = cpu_r;
               flags_d[FLAG_CF] = cpu_cf;
               flags_d[FLAG_SF] = cpu_sf;
               flags_d[FLAG_ZF] = cpu_zf;
               flags_d[FLAG_GF] = cpu_gf;
               valid_d          = 1'b1;
               count_d          = count_q + CNT_W'(1);
               state_d          = ST_RESP;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         ST_RESP: begin
            if (valid_q && res_ready) begin
               valid_d = 1'b0;
               state_d = (halt_on_zf && flags_q[FLAG_ZF]) ? ST_HALT : ST_IDLE;
            end
         end
         ST_HALT: begin
            if (resume) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pi_q     <= '0;
         settle_q <= '0;
         valid_q  <= 1'b0;
         r_q      <= '0;
         flags_q  <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pi_q     <= pi_d;
         settle_q <= settle_d;
         valid_q  <= valid_d;
         r_q      <= r_d;
         flags_q  <= flags_d;
         count_q  <= count_d;
      end
   end

   assign cpu_pi      = pi_q;
   assign res_valid   = valid_q;
   assign res_r       = r_q;
   assign res_flags   = flags_q;
   assign issue_count = count_q;
   assign halted      = (state_q == ST_HALT);
   assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_cpu_issue_sequencer.sv
// Directed bench for cpu_issue_sequencer with a combinational CPU stub.
module tb_cpu_issue_sequencer;

   logic       clk, rst;
   logic       in_valid, res_ready, halt_on_zf, resume;
   logic [9:0] in_instr;

   logic       in_ready, res_valid, halted, busy;
   logic [9:0] cpu_pi;
   logic [4:0] cpu_r, res_r;
   logic       cpu_cf, cpu_sf, cpu_zf, cpu_gf;
   logic [3:0] res_flags;
   logic [7:0] issue_count;

   logic       d2_in_ready, d2_res_valid, d2_halted, d2_busy;
   logic [9:0] d2_cpu_pi;
   logic [4:0] d2_cpu_r, d2_res_r;
   logic       d2_cf, d2_sf, d2_zf, d2_gf;
   logic [3:0] d2_res_flags;
   logic [1:0] d2_count;

   int n_tests = 0;
   int n_fail  = 0;

   assign cpu_r  = cpu_pi[4:0];
   assign cpu_zf = (cpu_pi[4:0] == 5'd0);
   assign cpu_cf = cpu_pi[5];
   assign cpu_sf = cpu_pi[4];
   assign cpu_gf = cpu_pi[9];

   assign d2_cpu_r = d2_cpu_pi[4:0];
   assign d2_zf    = (d2_cpu_pi[4:0] == 5'd0);
   assign d2_cf    = d2_cpu_pi[5];
   assign d2_sf    = d2_cpu_pi[4];
   assign d2_gf    = d2_cpu_pi[9];

   cpu_issue_sequencer #(.DEPTH(4), .SETTLE(1), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .cpu_pi(cpu_pi), .cpu_r(cpu_r),
      .cpu_cf(cpu_cf), .cpu_sf(cpu_sf), .cpu_zf(cpu_zf), .cpu_gf(cpu_gf),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_r(res_r), .res_flags(res_flags),
      .halt_on_zf(halt_on_zf), .resume(resume),
      .halted(halted), .busy(busy), .issue_count(issue_count)
   );

   cpu_issue_sequencer #(.DEPTH(4), .SETTLE(1), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(d2_in_ready), .in_instr(in_instr),
      .cpu_pi(d2_cpu_pi), .cpu_r(d2_cpu_r),
      .cpu_cf(d2_cf), .cpu_sf(d2_sf), .cpu_zf(d2_zf), .cpu_gf(d2_gf),
      .res_valid(d2_res_valid), .res_ready(res_ready),
      .res_r(d2_res_r), .res_flags(d2_res_flags),
      .halt_on_zf(halt_on_zf), .resume(resume),
      .halted(d2_halted), .busy(d2_busy), .issue_count(d2_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] exp_flags(input logic [9:0] w);
      return {w[9], (w[4:0] == 5'd0), w[4], w[5]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [9:0] w);
      in_valid = 1'b1;
      in_instr = w;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!res_valid && n < 20) begin
         step();
         n++;
      end
      chk("wait_valid", 32'(res_valid), 32'd1);
   endtask

   logic [9:0] bw [5];
   logic [9:0] wa, wb, h1, h2, w;
   int         n;

   initial begin
      bw = '{10'h0A3, 10'h215, 10'h3C0, 10'h1F1, 10'h08E};
      rst = 1'b1; in_valid = 1'b0; in_instr = '0;
      res_ready = 1'b0; halt_on_zf = 1'b0; resume = 1'b0;
      step();
      step();
      rst = 1'b0;

      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_halt", 32'(halted), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(issue_count), 32'd0);
      chk("rst_pi", 32'(cpu_pi), 32'd0);
      chk("rst_res", 32'({res_r, res_flags}), 32'd0);

      // single issue
      push(10'b0010100000);
      chk("t1_pi_e0", 32'(cpu_pi), 32'd0);
      step();
      chk("t1_pi_e1", 32'(cpu_pi), 32'(10'b0010100000));
      chk("t1_val_e1", 32'(res_valid), 32'd0);
      step();
      chk("t1_val_e2", 32'(res_valid), 32'd1);
      chk("t1_r", 32'(res_r), 32'd0);
      chk("t1_flags", 32'(res_flags), 32'(4'b0101));
      chk("t1_cnt", 32'(issue_count), 32'd1);
      res_ready = 1'b1;
      step();
      chk("t1_ack", 32'(res_valid), 32'd0);
      chk("t1_halt", 32'(halted), 32'd0);
      res_ready = 1'b0;

      // burst: one in flight, four queued
      for (int i = 0; i < 5; i++) push(bw[i]);
      chk("t2_full", 32'(in_ready), 32'd0);
      chk("t2_busy", 32'(busy), 32'd1);
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_valid(n);
         if (i > 0) chk("t2_gap", 32'(n), 32'd2);
         chk("t2_r", 32'(res_r), 32'(bw[i][4:0]));
         chk("t2_flags", 32'(res_flags), 32'(exp_flags(bw[i])));
         step();
      end
      chk("t2_cnt", 32'(issue_count), 32'd6);
      chk("t2_idle", 32'(busy), 32'd0);
      res_ready = 1'b0;

      // back-pressure
      wa = 10'h2B7;
      wb = 10'h155;
      push(wa);
      push(wb);
      wait_valid(n);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t3_val", 32'(res_valid), 32'd1);
         chk("t3_r", 32'(res_r), 32'(wa[4:0]));
         chk("t3_flags", 32'(res_flags), 32'(exp_flags(wa)));
         chk("t3_pi", 32'(cpu_pi), 32'(wa));
      end
      res_ready = 1'b1;
      step();
      wait_valid(n);
      chk("t3_gap", 32'(n), 32'd2);
      chk("t3_r2", 32'(res_r), 32'(wb[4:0]));
      step();
      res_ready = 1'b0;

      // halt on zero flag
      h1 = 10'b0100100000;
      h2 = 10'b1110100101;
      halt_on_zf = 1'b1;
      res_ready = 1'b1;
      push(h1);
      push(h2);
      wait_valid(n);
      chk("t4_flags1", 32'(res_flags), 32'(exp_flags(h1)));
      step();
      chk("t4_halted", 32'(halted), 32'd1);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t4_hold_val", 32'(res_valid), 32'd0);
         chk("t4_hold_pi", 32'(cpu_pi), 32'(h1));
      end
      chk("t4_busy", 32'(busy), 32'd1);
      resume = 1'b1;
      step();
      resume = 1'b0;
      chk("t4_resumed", 32'(halted), 32'd0);
      wait_valid(n);
      chk("t4_gap", 32'(n), 32'd2);
      chk("t4_r2", 32'(res_r), 32'(5'b00101));
      chk("t4_flags2", 32'(res_flags), 32'(exp_flags(h2)));
      step();
      chk("t4_no_halt", 32'(halted), 32'd0);
      halt_on_zf = 1'b0;
      res_ready = 1'b0;

      // reset mid-ISSUE with two queued
      push(10'h011);
      push(10'h022);
      push(10'h033);
      push(10'h044);
      chk("t5_stall", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      step();
      chk("t5_issue", 32'(cpu_pi), 32'h022);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_valid", 32'(res_valid), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_ready", 32'(in_ready), 32'd1);
      chk("t5_cnt", 32'(issue_count), 32'd0);
      chk("t5_pi", 32'(cpu_pi), 32'd0);
      step();
      step();
      step();
      chk("t5_quiet", 32'({res_valid, busy}), 32'd0);

      // counter wrap on the 2-bit instance
      res_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         w = 10'(k * 37);
         push(w);
         wait_valid(n);
         chk("t6_cnt2", 32'(d2_count), 32'(k % 4));
         chk("t6_cnt8", 32'(issue_count), 32'(k));
         step();
      end
      res_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
